// File: rtl/y_row_buffer.sv
// y_row_buffer: ping-pong row store between the MAC row counter and the
// output writer. Results captured on done fill one bank. en_y closes that row,
// and the row then drains over a valid/ready stream while the other bank fills.
// Optional feature macro: Y_ROW_SUM_EN adds a y_sum output, which is the running
// unsigned sum of the row being drained.
module y_row_buffer #(
    parameter int DW    = 16,
    parameter int DEPTH = 7,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          done,
    input  logic [DW-1:0] data_in,
    input  logic          en_y,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [DW-1:0] y_data,
    output logic          y_last,
    output logic          overflow,
    output logic          short_row
`ifdef Y_ROW_SUM_EN
    ,
    output logic [DW+CW-1:0] y_sum
`endif
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t        state, state_nxt;

    // Bank storage is deliberately not reset. Only the control state decides what is valid.
    logic [DW-1:0] mem [2][DEPTH];

    logic          fill_bank;
    logic          drain_bank;
    logic [CW-1:0] count;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] len [2];
    logic [1:0]    bank_full;

    logic          wr_ok;
    logic [CW-1:0] count_eff;
    logic          close_row;
    logic [1:0]    set_mask;
    logic [1:0]    clr_mask;
    logic [1:0]    full_next;
    logic          xfer;
    logic          last_beat;
    logic          last_xfer;

    // A write needs a free fill bank and room in the row. A done in the same
    // cycle as en_y is counted into the row before the row closes.
    assign wr_ok     = done && !bank_full[fill_bank] && (count < CW'(DEPTH));
    assign count_eff = count + {{(CW-1){1'b0}}, wr_ok};
    assign close_row = en_y && (count_eff != '0);
    assign set_mask  = {close_row & fill_bank, close_row & ~fill_bank};

    assign xfer      = y_valid && y_ready;
    assign last_beat = (rd_ptr == len[drain_bank] - CW'(1));
    assign last_xfer = xfer && last_beat;
    assign clr_mask  = {last_xfer & drain_bank, last_xfer & ~drain_bank};

    // The FSM looks at bank state including a row that closes this cycle. This
    // lets y_valid rise straight after the closing edge, and lets two back-to-back
    // full banks drain without a bubble.
    assign full_next = bank_full | set_mask;

    // Row data capture into the current fill bank.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[fill_bank][count] <= data_in;
    end

    // Fill-side bookkeeping: entry count, row close, and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            fill_bank <= 1'b0;
            len[0]    <= '0;
            len[1]    <= '0;
            overflow  <= 1'b0;
            short_row <= 1'b0;
        end else begin
            if (close_row) begin
                len[fill_bank] <= count_eff;
                count          <= '0;
                fill_bank      <= ~fill_bank;
                if (count_eff < CW'(DEPTH))
                    short_row <= 1'b1;
            end else if (wr_ok) begin
                count <= count + CW'(1);
            end
            if (done && !wr_ok)
                overflow <= 1'b1;
        end
    end

    // Bank ownership. Fill sets a bank's bit and drain clears it. The two never
    // touch the same bank in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bank_full <= 2'b00;
        else
            bank_full <= (bank_full | set_mask) & ~clr_mask;
    end

    // Drain read pointer and bank select.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            drain_bank <= 1'b0;
        end else if (last_xfer) begin
            rd_ptr     <= '0;
            drain_bank <= ~drain_bank;
        end else if (xfer) begin
            rd_ptr <= rd_ptr + CW'(1);
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Drain FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (full_next[drain_bank]) state_nxt = S_SEND;
            S_SEND: if (last_xfer) state_nxt = full_next[~drain_bank] ? S_SEND : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Drain FSM outputs. Data and last come from registered state only, so they
    // hold steady through a stall.
    always_comb begin
        y_valid = (state == S_SEND);
        y_data  = '0;
        y_last  = 1'b0;
        if (y_valid) begin
            y_data = mem[drain_bank][rd_ptr];
            y_last = last_beat;
        end
    end

`ifdef Y_ROW_SUM_EN
    logic [DW+CW-1:0] sum_acc;

    // Sum of beats already accepted in this row. It clears once the row finishes,
    // so it is zero when the next row drain starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sum_acc <= '0;
        else if (last_xfer)
            sum_acc <= '0;
        else if (xfer)
            sum_acc <= sum_acc + {{CW{1'b0}}, y_data};
    end

    // Include the beat on offer, so the total is complete on the y_last beat.
    assign y_sum = sum_acc + {{CW{1'b0}}, y_data};
`endif

endmodule

// File: tb/tb_y_row_buffer.sv
// Self-checking bench for y_row_buffer: a constant-expectation table, directed
// corner sequences, and random traffic against a queue-based row model.
// With Y_ROW_SUM_EN defined, the y_sum output is checked as well.
module tb_y_row_buffer;
    localparam int DW = 16, DEPTH = 7, CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          done = 1'b0, en_y = 1'b0, y_ready = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          y_valid, y_last, overflow, short_row;
    logic [DW-1:0] y_data;
`ifdef Y_ROW_SUM_EN
    logic [DW+CW-1:0] y_sum;
`endif

    y_row_buffer #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .done(done), .data_in(data_in), .en_y(en_y),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
        .overflow(overflow), .short_row(short_row)
`ifdef Y_ROW_SUM_EN
        , .y_sum(y_sum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model state.
    // cur holds the row being filled. pend_data holds closed rows back to back.
    // pend_len holds the length of each closed row.
    int unsigned cur[$];
    int unsigned pend_data[$];
    int          pend_len[$];
    int          pos;
    bit          m_ovf, m_short;
    longint unsigned m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        cur.delete(); pend_data.delete(); pend_len.delete();
        pos = 0; m_ovf = 0; m_short = 0; m_acc = 0;
    endfunction

    // One clock edge of the model. Free space is decided from the state before the edge.
    function automatic void m_edge(bit d, int unsigned di, bit e, bit r);
        bit valid, wr;
        valid = pend_len.size() > 0;
        wr    = d && (pend_len.size() < 2) && (cur.size() < DEPTH);
        if (valid && r) begin
            m_acc += pend_data[0];
            void'(pend_data.pop_front());
            pos++;
            if (pos == pend_len[0]) begin
                void'(pend_len.pop_front());
                pos = 0;
                m_acc = 0;
            end
        end
        if (wr) cur.push_back(di);
        else if (d) m_ovf = 1;
        if (e && cur.size() > 0) begin
            if (cur.size() < DEPTH) m_short = 1;
            foreach (cur[i]) pend_data.push_back(cur[i]);
            pend_len.push_back(cur.size());
            cur.delete();
        end
    endfunction

    task automatic compare_model();
        bit ev;
        ev = pend_len.size() > 0;
        chk("m_valid", y_valid, ev);
        if (ev) begin
            chk("m_data", y_data, pend_data[0] & 32'hFFFF);
            chk("m_last", y_last, pos == pend_len[0] - 1);
`ifdef Y_ROW_SUM_EN
            if (pos == pend_len[0] - 1) begin
                logic [DW+CW-1:0] s;
                s = (DW+CW)'(m_acc + pend_data[0]);
                chk("m_sum", y_sum, s);
            end
`endif
        end else begin
            chk("m_last_idle", y_last, 0);
        end
        chk("m_overflow", overflow, m_ovf);
        chk("m_short_row", short_row, m_short);
    endtask

    // Drive one cycle of inputs. The edge happens, the model advances, and DUT
    // outputs are compared on the falling edge.
    task automatic step(input bit d, input int unsigned di, input bit e, input bit r);
        done = d; data_in = di[DW-1:0]; en_y = e; y_ready = r;
        @(posedge clk);
        m_edge(d, di & 32'hFFFF, e, r);
        @(negedge clk);
        compare_model();
        done = 0; en_y = 0;
    endtask

    // Async reset check: outputs must clear before any clock edge occurs.
    task automatic do_reset();
        done = 0; en_y = 0; y_ready = 0;
        #2 reset = 0;
        #1;
        chk("rst_valid", y_valid, 0);
        chk("rst_data", y_data, 0);
        chk("rst_last", y_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_short_row", short_row, 0);
        m_reset();
        @(negedge clk);
        reset = 1;
    endtask

    typedef struct {
        bit d; int unsigned di; bit e; bit r;
        bit ev; int unsigned ed; bit el;
    } vec_t;

    vec_t tbl[15];
    bit   rpat[10] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 1};

    initial begin
        logic [DW-1:0] prev;
        m_reset();
        @(negedge clk);
        do_reset();

        // Full row 1..7, close, drain with ready held high.
        for (int i = 0; i < 7; i++) tbl[i] = '{1, i + 1, 0, 1, 0, 0, 0};
        tbl[7] = '{0, 0, 1, 1, 1, 1, 0};
        for (int i = 8; i < 14; i++) tbl[i] = '{0, 0, 0, 1, 1, i - 6, i == 13};
        tbl[14] = '{0, 0, 0, 1, 0, 0, 0};
        foreach (tbl[i]) begin
            step(tbl[i].d, tbl[i].di, tbl[i].e, tbl[i].r);
            chk("tbl_valid", y_valid, tbl[i].ev);
            if (tbl[i].ev) chk("tbl_data", y_data, tbl[i].ed);
            chk("tbl_last", y_last, tbl[i].el);
        end
        chk("tbl_overflow", overflow, 0);
        chk("tbl_short_row", short_row, 0);

        // Both banks full, then overflow, an ignored en_y, and a gapless drain.
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 10 + i, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 20 + i, 0, 0);
        step(0, 0, 1, 0);
        step(1, 99, 0, 0);
        chk("ovf_set", overflow, 1);
        step(0, 0, 1, 0);
        chk("ovf_no_short", short_row, 0);
        for (int k = 0; k < 14; k++) begin
            chk("b2b_valid", y_valid, 1);
            chk("b2b_data", y_data, (k < 7) ? 10 + k : 13 + k);
            chk("b2b_last", y_last, (k == 6) || (k == 13));
            step(0, 0, 0, 1);
        end
        chk("b2b_empty", y_valid, 0);

        // Short row of 4 entries.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 5 + i, 0, 1);
        step(0, 0, 1, 1);
        chk("short_set", short_row, 1);
        for (int k = 0; k < 4; k++) begin
            chk("short_data", y_data, 5 + k);
            chk("short_last", y_last, k == 3);
            step(0, 0, 0, 1);
        end
        chk("short_empty", y_valid, 0);

        // done and en_y in the same cycle complete a 7-entry row.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 1 + i, 0, 0);
        step(1, 9, 1, 0);
        chk("same_cyc_short", short_row, 0);
        for (int k = 0; k < 7; k++) step(0, 0, 0, 1);
        chk("same_cyc_empty", y_valid, 0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 1 + i, 0, 0);
        step(1, 9, 1, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1);
        chk("same_cyc_last_data", y_data, 9);
        chk("same_cyc_last_flag", y_last, 1);

        // Stall with y_ready 1,0,0,1,...: data must hold while stalled.
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 31 + i, 0, 0);
        step(0, 0, 1, 0);
        foreach (rpat[i]) begin
            prev = y_data;
            step(0, 0, 0, rpat[i]);
            if (!rpat[i]) chk("stall_hold", y_data, prev);
        end
        chk("stall_drained", y_valid, 0);

        // Reset in the middle of a drain, then a clean row from bank 0.
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 41 + i, 0, 0);
        step(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
        chk("mid_drain_data", y_data, 44);
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 51 + i, 0, 1);
        step(0, 0, 1, 1);
        chk("post_rst_first", y_data, 51);
        for (int k = 0; k < 7; k++) step(0, 0, 0, 1);

        // Random traffic, with an occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 1), $urandom, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/y_row_buffer.md
Name: y_row_buffer

Overview:
- Downstream consumer of the row counter, which asserts en_y after 7 done pulses.
- Captures each MAC result on its done pulse into a ping-pong pair of row banks.
- Closes a row when en_y arrives, then drains the completed row over a valid/ready stream to the output writer.
- Double-buffering lets the next row fill while the previous one drains.

Parameters:
- DW, 16, result data width.
- DEPTH, 7, entries per row bank; matches the counter's terminal count.
- CW, 3, bank count/pointer width; must satisfy 2**CW > DEPTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- done  in  1  one-cycle pulse; data_in valid this cycle.
- data_in  in  DW  MAC result accompanying done.
- en_y  in  1  row-complete pulse from the counter.
- y_valid  out  1  drain beat valid.
- y_ready  in  1  downstream accepts the beat.
- y_data  out  DW  current drain entry.
- y_last  out  1  final entry of the row being drained.
- overflow  out  1  sticky: done arrived with no free bank.
- short_row  out  1  sticky: a row closed with count < DEPTH.

Behaviour:
- Reset (reset=0, async): y_valid=0, y_data=0, y_last=0, overflow=0, short_row=0, fill_bank=0, drain_bank=0, both bank_full=0, counts and pointers=0. Bank contents are not reset.
- Fill side: on done with the fill bank not full and count < DEPTH:
  - bank[fill_bank][count] <= data_in; count++ at that edge.
- done when count == DEPTH or the fill bank is full: data dropped, overflow <= 1.
- en_y with count > 0:
  - bank_full[fill_bank] <= 1, len[fill_bank] <= count, count <= 0, fill_bank toggles.
  - If count < DEPTH, short_row <= 1.
- en_y with count == 0 is ignored and has no flag effect.
- done and en_y in the same cycle: the done write is counted into the row first, then the row closes (length = count+1).
- Drain FSM states:
  - IDLE: y_valid=0; go to SEND when bank_full[drain_bank].
  - SEND: y_valid=1, y_data=bank[drain_bank][rd_ptr], y_last=(rd_ptr==len-1).
    - Transfer on y_valid & y_ready: rd_ptr++.
    - On the last transfer: bank_full[drain_bank] <= 0, rd_ptr <= 0, drain_bank toggles, next state IDLE (SEND if the other bank is already full).
- Latency:
  - y_valid is registered; it rises the cycle after the en_y edge that closes a row.
  - Back-to-back full banks drain without a bubble beat.
- y_data and y_last hold stable while y_valid=1 and y_ready=0.
- A bank freed by the final drain transfer is writable by done in the following cycle.
- Both banks full: further done pulses set overflow; en_y is ignored.
- Reset mid-drain or mid-fill aborts immediately to the reset state; the partial row is discarded.
- overflow and short_row clear only on reset.

Optional Feature:
- Macro Y_ROW_SUM_EN.
- When defined:
  - Adds output y_sum, width DW+CW: running unsigned sum of the row's entries during drain.
  - Value is valid and complete on the y_last beat.
  - The sum register is cleared at the start of each row drain.
  - Wraps modulo 2**(DW+CW).
- When undefined: no y_sum port and no adder logic; all other behaviour is identical.

Test Plan:
- Reset, then 7 done pulses with data 1..7, then en_y, y_ready=1 → y_valid rises the cycle after en_y; beats 1..7 on consecutive cycles; y_last only on 7; y_sum=28 if Y_ROW_SUM_EN; flags stay 0.
- Two 7-pulse bursts (10..16, 20..26) with y_ready=0 until both close → both banks full; 8th done sets overflow=1; with y_ready=1 drain emits 10..16 then 20..26 with no gap; y_last on 16 and 26.
- 4 done pulses (5,6,7,8), then en_y → short_row=1; drain emits 4 beats, y_last on 8.
- Done with data 9 and en_y in the same cycle after 6 prior done pulses → row length 7, last beat 9, short_row=0.
- y_ready toggling 1,0,0,1 during drain → y_data held constant while stalled; no beat lost or duplicated.
- reset asserted after 3 drained beats → all outputs 0 immediately; a new 7-pulse row afterwards drains correctly from bank 0.
